// File: rtl/oai211_sdff_bank.sv
// ---------------------------------------------------------------------------
// oai211_sdff_bank
// Registered bank of WIDTH compound-gate channels. Each channel computes
// OAI211 (MODE=0) or AOI211 (MODE=1). The result passes through a PIPE-deep
// register pipeline whose last stage is ZN. In scan mode the output register
// becomes a shift chain. A saturating counter accumulates ZN bit toggles on
// functional update edges.
//
// Ports
//   CK       clock, rising edge
//   RN       asynchronous active-low reset
//   EN       functional enable for all pipeline stages and the counter
//   MODE     0 = OAI211, 1 = AOI211
//   A,B,C1,C2 per-channel gate inputs [WIDTH]
//   SE, SI   scan enable (overrides EN) and scan-in bit
//   CLR_CNT  synchronous clear of TGL_CNT/TGL_SAT, highest priority
//   ZN       output register [WIDTH]
//   SO       scan-out, ZN[WIDTH-1]
//   TGL_CNT  saturating toggle count [CW]
//   TGL_SAT  registered flag, TGL_CNT at all-ones
// ---------------------------------------------------------------------------

// One channel of the compound gate.
module oai211_sdff_ch (
    input  logic i_mode,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c1,
    input  logic i_c2,
    output logic o_f
);
    assign o_f = i_mode ? ~((i_c1 & i_c2) | i_a | i_b)
                        : ~((i_c1 | i_c2) & i_a & i_b);
endmodule

module oai211_sdff_bank #(
    parameter int WIDTH = 4,
    parameter int PIPE  = 2,
    parameter int CW    = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C1,
    input  logic [WIDTH-1:0] C2,
    input  logic             SE,
    input  logic             SI,
    input  logic             CLR_CNT,
    output logic [WIDTH-1:0] ZN,
    output logic             SO,
    output logic [CW-1:0]    TGL_CNT,
    output logic             TGL_SAT
);
    // Seven extra bits hold a popcount of up to 64 on top of a full count.
    localparam int SW = CW + 7;
    localparam logic [SW-1:0] SUM_MAX = {{7{1'b0}}, {CW{1'b1}}};

    logic [PIPE-1:0][WIDTH-1:0] r_pipe;   // index PIPE-1 is the output register
    logic [PIPE-1:0][WIDTH-1:0] w_pnext;
    logic [WIDTH-1:0]           w_f;
    logic [WIDTH-1:0]           w_scan;
    logic [WIDTH-1:0]           w_diff;
    logic [6:0]                 w_pop;
    logic [SW-1:0]              w_sum;
    logic [CW-1:0]              w_cnt_inc;
    logic [CW-1:0]              r_cnt;
    logic                       r_sat;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            oai211_sdff_ch u_ch (
                .i_mode (MODE),
                .i_a    (A[gi]),
                .i_b    (B[gi]),
                .i_c1   (C1[gi]),
                .i_c2   (C2[gi]),
                .o_f    (w_f[gi])
            );
        end
    endgenerate

    // Functional next state: stage 0 takes the gate, each later stage takes
    // its predecessor. Loops keep PIPE=1 and WIDTH=1 free of negative slices.
    always_comb begin
        w_pnext    = '0;
        w_pnext[0] = w_f;
        for (int k = 1; k < PIPE; k++) w_pnext[k] = r_pipe[k-1];
    end

    always_comb begin
        w_scan    = '0;
        w_scan[0] = SI;
        for (int i = 1; i < WIDTH; i++) w_scan[i] = r_pipe[PIPE-1][i-1];
    end

    assign w_diff = w_pnext[PIPE-1] ^ r_pipe[PIPE-1];

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) w_pop = w_pop + {6'd0, w_diff[i]};
    end

    assign w_sum     = {7'd0, r_cnt} + {{CW{1'b0}}, w_pop};
    assign w_cnt_inc = (w_sum >= SUM_MAX) ? {CW{1'b1}} : w_sum[CW-1:0];

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_pipe <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else begin
            // Scan shifts only the output register; inner stages hold.
            if (SE)      r_pipe[PIPE-1] <= w_scan;
            else if (EN) r_pipe         <= w_pnext;

            if (CLR_CNT) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (!SE && EN) begin
                r_cnt <= w_cnt_inc;
                r_sat <= (w_cnt_inc == {CW{1'b1}});
            end
        end
    end

    assign ZN      = r_pipe[PIPE-1];
    assign SO      = r_pipe[PIPE-1][WIDTH-1];
    assign TGL_CNT = r_cnt;
    assign TGL_SAT = r_sat;
endmodule
